// File: rtl/pipeline_reg_chain_pkg.sv
// Shared elaboration helpers for the pipeline register chain: width math and
// the legal DEPTH range.
package pipeline_reg_chain_pkg;

    localparam int unsigned MinDepth = 1;
    localparam int unsigned MaxDepth = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit depth_legal(input int unsigned depth);
        return (depth >= MinDepth) && (depth <= MaxDepth);
    endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline stage: a valid flag plus payload register, with load and kill
// controls supplied by the chain's advance logic.
module pipe_stage_cell #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             kill_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Load wins over kill so a flushed or departing stage can be refilled on the same edge.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (kill_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipeline_reg_chain.sv
// Elastic chain of DEPTH register stages with bubble collapse, freeze stall and
// per-stage flush; exposes every stage for hazard/forward snooping.
module pipeline_reg_chain
    import pipeline_reg_chain_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      freeze,
    input  logic [DEPTH-1:0]          flush,
    output logic [DEPTH-1:0]          stage_valid,
    output logic [DEPTH*WIDTH-1:0]    stage_data,
    output logic [clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned OccW = clog2(DEPTH + 1);

    if (!depth_legal(DEPTH)) begin : g_depth_check
        $error("pipeline_reg_chain: DEPTH must be within 1..16");
    end

    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] move;

    // A stage being flushed this cycle is treated as empty for every advance decision.
    assign live = stage_valid & ~flush;

    always_comb begin
        move = '0;
        move[DEPTH-1] = live[DEPTH-1] & out_ready & ~freeze;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            move[i] = live[i] & ~freeze & (~live[i+1] | move[i+1]);
        end
    end

    assign in_ready  = ~rst & ~freeze & (~live[0] | move[0]);
    assign out_valid = live[DEPTH-1] & ~freeze;
    assign out_data  = stage_data[(DEPTH-1)*WIDTH +: WIDTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             load_s;
        logic [WIDTH-1:0] src_s;

        if (g == 0) begin : g_head
            assign load_s = in_valid & in_ready;
            assign src_s  = in_data;
        end else begin : g_body
            assign load_s = move[g-1];
            assign src_s  = stage_data[(g-1)*WIDTH +: WIDTH];
        end

        pipe_stage_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .load_i (load_s),
            .kill_i (flush[g] | move[g]),
            .data_i (src_s),
            .valid_o(stage_valid[g]),
            .data_o (stage_data[g*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occupancy = occupancy + OccW'(stage_valid[i]);
        end
    end

endmodule

// File: tb/tb_pipeline_reg_chain.sv
// Bench for pipeline_reg_chain: directed scenarios plus randomized traffic
// checked against an item-list reference model.
module tb_pipeline_reg_chain;

    localparam int W = 32;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic           freeze = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic [D-1:0]   flush = '0;
    logic           in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [D-1:0]   stage_valid;
    logic [D*W-1:0] stage_data;
    logic [2:0]     occupancy;

    int checks = 0;
    int errors = 0;

    pipeline_reg_chain #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .freeze     (freeze),
        .flush      (flush),
        .stage_valid(stage_valid),
        .stage_data (stage_data),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    // Reference model: ordered list of items (oldest first), each at a stage position.
    typedef struct packed {
        logic [W-1:0] data;
        int           pos;
    } item_t;

    item_t        mq[$];
    item_t        nq[$];
    logic         exp_in_ready;
    logic         exp_out_valid;
    logic [W-1:0] exp_out_data;
    logic [D-1:0] exp_sv;
    int           exp_occ;

    task automatic model_eval();
        item_t tmp[$];
        item_t it;
        int    limit;
        exp_sv        = '0;
        exp_out_valid = 1'b0;
        exp_out_data  = '0;
        exp_occ       = mq.size();
        foreach (mq[k]) exp_sv[mq[k].pos] = 1'b1;
        tmp = {};
        foreach (mq[k]) if (!flush[mq[k].pos]) tmp.push_back(mq[k]);
        if (!freeze) begin
            foreach (tmp[k]) begin
                if (tmp[k].pos == D - 1) begin
                    exp_out_valid = 1'b1;
                    exp_out_data  = tmp[k].data;
                end
            end
        end
        nq    = {};
        limit = D;
        foreach (tmp[k]) begin
            it = tmp[k];
            if (!freeze && it.pos == D - 1 && out_ready) begin
                // consumed downstream
            end else begin
                if (!freeze && it.pos + 1 < limit) it.pos = it.pos + 1;
                limit = it.pos;
                nq.push_back(it);
            end
        end
        exp_in_ready = !freeze && (limit > 0);
        if (in_valid && exp_in_ready) nq.push_back('{data: in_data, pos: 0});
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        mq = nq;
        #1;
    endtask

    task automatic send(input logic [W-1:0] value);
        in_valid = 1'b1;
        in_data  = value;
        #1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (stage_valid !== '0) begin errors++; $display("FAIL reset_stage_valid: got %b want 0", stage_valid); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        checks++; if (stage_data !== '0) begin errors++; $display("FAIL reset_stage_data: got %h want 0", stage_data); end
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_A5A5;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        for (int e = 1; e <= 3; e++) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_out_valid: edge %0d got %b want 0", e, out_valid); end
            tick();
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL single_out_data: got %h want a5a5a5a5", out_data); end
        tick();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL single_occupancy: got %0d want 0", occupancy); end
    endtask

    task automatic test_stream();
        int sent  = 1;
        int got   = 0;
        int first = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (sent <= 10);
            in_data  = 32'(sent);
            #1;
            if (sent <= 10) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: cycle %0d got %b want 1", c, in_ready); end
            end
            if (out_valid === 1'b1) begin
                if (first < 0) first = c;
                checks++;
                if (out_data !== 32'(got + 1) || c != first + got) begin
                    errors++;
                    $display("FAIL stream_out: cycle %0d got %0d want %0d at cycle %0d", c, out_data, got + 1, first + got);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (got != 10) begin errors++; $display("FAIL stream_count: got %0d want 10", got); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(32'h100 + 32'(k));
        in_valid = 1'b1;
        in_data  = 32'hDEAD;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occupancy: got %0d want 4", occupancy); end
        checks++; if (stage_valid !== 4'hF) begin errors++; $display("FAIL full_stage_valid: got %b want 1111", stage_valid); end
        tick();
        checks++; if (stage_data[W-1:0] !== 32'h103) begin errors++; $display("FAIL full_hold_s0: got %h want 103", stage_data[W-1:0]); end
        checks++; if (out_data !== 32'h100) begin errors++; $display("FAIL full_hold_out: got %h want 100", out_data); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            if (j == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL full_shift_in_ready: got %b want 1", in_ready); end
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h100 + 32'(j)) begin
                errors++;
                $display("FAIL drain_out: beat %0d got v=%b d=%h want v=1 d=%h", j, out_valid, out_data, 32'h100 + 32'(j));
            end
            tick();
        end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL drain_occupancy: got %0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        logic [W-1:0] got[$];
        out_ready = 1'b1;
        send(32'hA1);
        send(32'hB2);
        send(32'hC3);
        flush = 4'b0010;
        #1;
        checks++; if (stage_valid !== 4'b0111) begin errors++; $display("FAIL flush_pre_valid: got %b want 0111", stage_valid); end
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL flush_pre_occupancy: got %0d want 3", occupancy); end
        tick();
        flush = '0;
        #1;
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL flush_post_occupancy: got %0d want 2", occupancy); end
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid === 1'b1) got.push_back(out_data);
            tick();
        end
        checks++; if (got.size() != 2) begin errors++; $display("FAIL flush_count: got %0d want 2", got.size()); end
        if (got.size() >= 2) begin
            checks++;
            if (got[0] !== 32'hA1 || got[1] !== 32'hC3) begin
                errors++;
                $display("FAIL flush_order: got %h,%h want a1,c3", got[0], got[1]);
            end
        end
    endtask

    task automatic test_freeze_flush();
        logic [W-1:0] got[$];
        out_ready = 1'b1;
        send(32'h11);
        send(32'h22);
        send(32'h33);
        freeze   = 1'b1;
        flush    = 4'b0001;
        in_valid = 1'b1;
        in_data  = 32'h44;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL freeze_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL freeze_in_ready: got %b want 0", in_ready); end
        tick();
        flush = '0;
        for (int f = 0; f < 3; f++) begin
            #1;
            checks++;
            if (stage_valid !== 4'b0110 || stage_data[2*W +: W] !== 32'h11 || stage_data[W +: W] !== 32'h22) begin
                errors++;
                $display("FAIL freeze_hold: step %0d got sv=%b s2=%h s1=%h want 0110 11 22",
                         f, stage_valid, stage_data[2*W +: W], stage_data[W +: W]);
            end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL freeze_out_valid_hold: got %b want 0", out_valid); end
            if (f < 2) tick();
        end
        freeze   = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid === 1'b1) got.push_back(out_data);
            tick();
        end
        checks++; if (got.size() != 2) begin errors++; $display("FAIL freeze_count: got %0d want 2", got.size()); end
        if (got.size() >= 2) begin
            checks++;
            if (got[0] !== 32'h11 || got[1] !== 32'h22) begin
                errors++;
                $display("FAIL freeze_order: got %h,%h want 11,22", got[0], got[1]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        send(32'h7);
        send(32'h8);
        send(32'h9);
        #2;
        rst = 1'b1;
        mq.delete();
        #1;
        checks++; if (stage_valid !== '0) begin errors++; $display("FAIL midreset_stage_valid: got %b want 0", stage_valid); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset_in_ready: got %b want 0", in_ready); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL midreset_occupancy: got %0d want 0", occupancy); end
        @(negedge clk);
        rst = 1'b0;
        send(32'h5);
        #1;
        for (int e = 1; e <= 3; e++) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_early: edge %0d got %b want 0", e, out_valid); end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h5) begin
            errors++;
            $display("FAIL midreset_latency: got v=%b d=%h want v=1 d=5", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 6);
            freeze    = ($urandom_range(0, 9) == 0);
            flush     = '0;
            if ($urandom_range(0, 9) == 0) flush = 4'($urandom_range(1, 15));
            #1;
            model_eval();
            checks++; if (in_ready !== exp_in_ready) begin errors++; $display("FAIL rand_in_ready: cycle %0d got %b want %b", c, in_ready, exp_in_ready); end
            checks++; if (out_valid !== exp_out_valid) begin errors++; $display("FAIL rand_out_valid: cycle %0d got %b want %b", c, out_valid, exp_out_valid); end
            if (exp_out_valid) begin
                checks++;
                if (out_data !== exp_out_data) begin errors++; $display("FAIL rand_out_data: cycle %0d got %h want %h", c, out_data, exp_out_data); end
            end
            checks++; if (stage_valid !== exp_sv) begin errors++; $display("FAIL rand_stage_valid: cycle %0d got %b want %b", c, stage_valid, exp_sv); end
            checks++; if (occupancy !== 3'(exp_occ)) begin errors++; $display("FAIL rand_occupancy: cycle %0d got %0d want %0d", c, occupancy, exp_occ); end
            foreach (mq[k]) begin
                checks++;
                if (stage_data[mq[k].pos*W +: W] !== mq[k].data) begin
                    errors++;
                    $display("FAIL rand_stage_data: cycle %0d stage %0d got %h want %h",
                             c, mq[k].pos, stage_data[mq[k].pos*W +: W], mq[k].data);
                end
            end
            tick();
        end
        in_valid  = 1'b0;
        freeze    = 1'b0;
        flush     = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        #1;
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rand_final_occupancy: got %0d want 0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_freeze_flush();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
